// File: rtl/ins_fetch_pkg.sv
// Shared widths, fetch FSM encodings and reset vector for the instruction fetch path.
// No logic, so no latency or backpressure of its own.
package ins_fetch_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [15:0] RESET_VEC = 16'h0000;
endpackage

// File: rtl/ins_fetch_if.sv
// PC/ROM/decoder signal bundle around ins_fetch; slave = fetch unit, master = its environment.
// Pure wiring: no latency; pc_stall and ins_ready carry the backpressure.
interface ins_fetch_if
  import ins_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [ADDR_W-1:0] pc_addr;
  logic              pc_valid;
  logic              pc_stall;
  logic              flush;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              ins_valid;
  logic              ins_ready;
  logic [DATA_W-1:0] ins_data;
  logic [ADDR_W-1:0] ins_addr;
`ifdef INS_PARITY_EN
  logic              rom_par;
  logic              ins_err;
`endif

  modport slave (
    input  pc_addr, pc_valid, flush, rom_data, ins_ready,
`ifdef INS_PARITY_EN
    input  rom_par,
    output ins_err,
`endif
    output pc_stall, rom_en, rom_addr, ins_valid, ins_data, ins_addr
  );

  modport master (
    output pc_addr, pc_valid, flush, rom_data, ins_ready,
`ifdef INS_PARITY_EN
    output rom_par,
    input  ins_err,
`endif
    input  pc_stall, rom_en, rom_addr, ins_valid, ins_data, ins_addr
  );
endinterface

// File: rtl/ins_fifo.sv
// Generic DEPTH-entry FIFO with synchronous clear; zero-latency head, push-to-visible 1 cycle.
// No internal backpressure: the owner must never push when full (checked by assertion).
module ins_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_clear,
  input  logic [W-1:0]               i_dat,
  output logic [W-1:0]               o_dat,
  output logic                       o_vld,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst_n && !i_clear && i_push) r_mem[r_wr] <= i_dat;
  end

  assign o_vld   = (r_count != '0);
  assign o_dat   = o_vld ? r_mem[r_rd] : '0;
  assign o_count = r_count;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && !i_pop && !i_clear && r_count == CW'(DEPTH)));
endmodule

// File: rtl/ins_fetch.sv
// Fetch unit: PC address -> sync ROM -> {addr,data} buffer -> decoder; issue to ins_valid is 2 cycles.
// Stalls the PC when buffer plus in-flight word would overflow; INS_PARITY_EN adds rom_par/ins_err.
module ins_fetch
  import ins_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  ins_fetch_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;
`ifdef INS_PARITY_EN
  localparam int EW = ADDR_W + DATA_W + 1;
`else
  localparam int EW = ADDR_W + DATA_W;
`endif

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inf_addr;
  logic [CW-1:0]     w_count;
  logic              w_vld;
  logic              w_run;
  logic              w_room;
  logic              w_pop;
  logic              w_issue_ok;
  logic              w_accept;
  logic              w_push;
  logic [EW-1:0]     w_push_dat;
  logic [EW-1:0]     w_head;

  assign w_run      = (r_state == S_RUN);
  assign w_pop      = w_vld && bus.ins_ready;
  // Credit check counts the word still in the ROM so a full buffer is never overrun.
  assign w_room     = (w_count + CW'(r_inflight)) < CW'(DEPTH);
  assign w_issue_ok = w_run && !bus.flush && (w_room || w_pop);
  assign w_accept   = w_issue_ok && bus.pc_valid;
  assign w_push     = r_inflight && w_run && !bus.flush;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_RUN;
      S_RUN:   if (bus.flush && r_inflight) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_inflight <= 1'b0;
      r_inf_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_accept;
      if (w_accept) r_inf_addr <= bus.pc_addr;
    end
  end

`ifdef INS_PARITY_EN
  assign w_push_dat = {r_inf_addr, bus.rom_data, bus.rom_par};
`else
  assign w_push_dat = {r_inf_addr, bus.rom_data};
`endif

  ins_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop && !bus.flush),
    .i_clear (bus.flush),
    .i_dat   (w_push_dat),
    .o_dat   (w_head),
    .o_vld   (w_vld),
    .o_count (w_count)
  );

  assign bus.pc_stall  = !w_issue_ok;
  assign bus.rom_en    = w_accept;
  assign bus.rom_addr  = w_accept ? bus.pc_addr : ADDR_W'(RESET_VEC);
  assign bus.ins_valid = w_vld;
  assign bus.ins_addr  = w_head[EW-1 -: ADDR_W];
`ifdef INS_PARITY_EN
  assign bus.ins_data  = w_head[DATA_W:1];
  assign bus.ins_err   = w_vld && (^w_head[DATA_W:0]);
`else
  assign bus.ins_data  = w_head[DATA_W-1:0];
`endif
endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch: reset, streaming, back-pressure, flush and (INS_PARITY_EN) parity.
// ROM model returns addr ^ 16'hA5A5 one cycle after rom_en.
module tb_ins_fetch;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [15:0] dq[$];
  logic [15:0] exp_s [4] = '{16'hA5A5, 16'hA5A4, 16'hA5A7, 16'hA5A6};

  ins_fetch_if bus ();

  ins_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.rom_en) begin
      bus.rom_data <= bus.rom_addr ^ 16'hA5A5;
`ifdef INS_PARITY_EN
      bus.rom_par  <= (^(bus.rom_addr ^ 16'hA5A5)) ^ (bus.rom_addr == 16'd7);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a PC that advances only when its request is accepted, and checks delivery order.
  task automatic run_pc(input int pc_first, input int pc_last, input int d_first,
                        input int d_last, input int ncyc, input logic [3:0] rdy_pat);
    int nxt;
    int k;
    nxt = pc_first;
    dq.delete();
    for (int c = 0; c < ncyc; c++) begin
      tick();
      bus.pc_valid  = (nxt <= pc_last);
      bus.pc_addr   = 16'(nxt);
      bus.ins_ready = rdy_pat[c % 4];
      #1;
      if (bus.ins_valid && bus.ins_ready) begin
        k = d_first + dq.size();
        chk("dlv_addr", 32'(bus.ins_addr), 32'(k));
        chk("dlv_data", 32'(bus.ins_data), 32'(16'(k) ^ 16'hA5A5));
        dq.push_back(bus.ins_addr);
      end
      if (bus.pc_valid && !bus.pc_stall) nxt++;
    end
    bus.pc_valid  = 1'b0;
    bus.ins_ready = 1'b0;
    chk("dlv_count", 32'(dq.size()), 32'(d_last - d_first + 1));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.pc_valid  = 1'b1;
    bus.pc_addr   = 16'h1234;
    bus.flush     = 1'b0;
    bus.ins_ready = 1'b0;
    bus.rom_data  = '0;
`ifdef INS_PARITY_EN
    bus.rom_par   = 1'b0;
`endif

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_rom_en", 32'(bus.rom_en), 32'd0);
      chk("rst_ins_valid", 32'(bus.ins_valid), 32'd0);
      chk("rst_pc_stall", 32'(bus.pc_stall), 32'd1);
    end
    chk("rst_ins_data", 32'(bus.ins_data), 32'd0);
    chk("rst_ins_addr", 32'(bus.ins_addr), 32'd0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
`ifdef INS_PARITY_EN
    chk("rst_ins_err", 32'(bus.ins_err), 32'd0);
`endif

    tick();
    rst_n = 1'b1;
    bus.pc_valid = 1'b0;
    #1;
    chk("idle_pc_stall", 32'(bus.pc_stall), 32'd1);

    // Streaming with decoder always ready
    for (int i = 0; i < 7; i++) begin
      tick();
      bus.ins_ready = 1'b1;
      bus.pc_valid  = (i < 4);
      bus.pc_addr   = 16'(i);
      #1;
      if (i < 4) begin
        chk("str_pc_stall", 32'(bus.pc_stall), 32'd0);
        chk("str_rom_addr", 32'(bus.rom_addr), 32'(i));
      end
      if (i >= 2 && i < 6) begin
        chk("str_ins_valid", 32'(bus.ins_valid), 32'd1);
        chk("str_ins_data", 32'(bus.ins_data), 32'(exp_s[i-2]));
      end else begin
        chk("str_ins_idle", 32'(bus.ins_valid), 32'd0);
      end
    end

    // Back-pressure: decoder not ready, PC presents 0 then 1 then holds 2
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.ins_ready = 1'b0;
      bus.pc_valid  = 1'b1;
      bus.pc_addr   = (i == 0) ? 16'd0 : (i == 1) ? 16'd1 : 16'd2;
      #1;
      chk("bp_pc_stall", 32'(bus.pc_stall), (i < 2) ? 32'd0 : 32'd1);
      if (i >= 2) begin
        chk("bp_rom_en", 32'(bus.rom_en), 32'd0);
        chk("bp_head_addr", 32'(bus.ins_addr), 32'd0);
        chk("bp_head_data", 32'(bus.ins_data), 32'hA5A5);
      end
    end
    run_pc(2, 5, 0, 5, 14, 4'b1111);

    // Alternating ready: buffer cycles through full with pop+issue, pointers wrap
    run_pc(20, 25, 20, 25, 24, 4'b0101);

    // Flush while word 11 returns; it must never reach the decoder
    tick(); bus.pc_valid = 1'b1; bus.pc_addr = 16'd10; #1;
    chk("fl_issue10", 32'(bus.pc_stall), 32'd0);
    tick(); bus.pc_addr = 16'd11; #1;
    chk("fl_issue11", 32'(bus.pc_stall), 32'd0);
    tick(); bus.flush = 1'b1; bus.pc_addr = 16'd40; #1;
    chk("fl_stall", 32'(bus.pc_stall), 32'd1);
    chk("fl_rom_en", 32'(bus.rom_en), 32'd0);
    chk("fl_head10", 32'(bus.ins_addr), 32'd10);
    tick(); bus.flush = 1'b0; #1;
    chk("fl_drain_stall", 32'(bus.pc_stall), 32'd1);
    chk("fl_drain_valid", 32'(bus.ins_valid), 32'd0);
    tick(); #1;
    chk("fl_issue40", 32'(bus.pc_stall), 32'd0);
    chk("fl_rom_addr40", 32'(bus.rom_addr), 32'd40);
    tick(); bus.pc_valid = 1'b0; bus.ins_ready = 1'b1; #1;
    chk("fl_gap_valid", 32'(bus.ins_valid), 32'd0);
    tick(); #1;
    chk("fl_valid40", 32'(bus.ins_valid), 32'd1);
    chk("fl_addr40", 32'(bus.ins_addr), 32'd40);
    chk("fl_data40", 32'(bus.ins_data), 32'hA58D);
    tick(); #1;
    chk("fl_empty", 32'(bus.ins_valid), 32'd0);

`ifdef INS_PARITY_EN
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.ins_ready = 1'b1;
      bus.pc_valid  = (i < 3);
      bus.pc_addr   = 16'(6 + i);
      #1;
      if (i >= 2 && i < 5) chk("par_addr", 32'(bus.ins_addr), 32'(4 + i));
      chk("par_err", 32'(bus.ins_err), (i == 3) ? 32'd1 : 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
